// File: rtl/arith_pkg.sv
// Shared opcode/state types and opcode classification helpers for the arithmetic unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package arith_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  // DIV and MOD both go through the iterative divider.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Codes above OP_MOD are reserved and flagged as illegal.
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_MOD;
  endfunction

endpackage

// File: rtl/arith_divider.sv
// Restoring shift-subtract divider producing one quotient bit per cycle, MSB first.
// Latency: start at edge N, done pulse visible after edge N+WIDTH.
// Backpressure: none; results stay in the quotient/remainder registers until the next start.
module arith_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", which naturally yields all-ones quotient and remainder=dividend.
  always_comb begin
    trial  = {rem_q, quot_q[WIDTH-1]};
    diff   = trial - {1'b0, dvs_q};
    ge     = trial >= {1'b0, dvs_q};
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    div0_d = div0_q;
    if (start_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      div0_d = (divisor_i == '0);
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], ge};
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      div0_q <= div0_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div0_o      = div0_q;

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked ADD/SUB/MUL/DIV/MOD unit with registered result and div0/op_err flags.
// Latency: accept at edge N -> out_valid after N+1 (ADD/SUB/MUL/illegal) or N+WIDTH+1 (DIV/MOD).
// Backpressure: result and flags hold in DONE until out_ready; no new accept until after that handshake.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RES_W = 2 * WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             div0,
  output logic             op_err
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             div0_q, div0_d;
  logic             op_err_q, op_err_d;

  logic             accept;
  logic             dv_busy, dv_done, dv_div0;
  logic [WIDTH-1:0] dv_quot, dv_rem;
  logic [RES_W-1:0] a_x, b_x, alu_res;

  localparam int PAD = RES_W - WIDTH;

  // pend_q covers the single operand-latch cycle of the one-cycle ops.
  assign in_ready  = (state_q == IDLE) && !pend_q && !dv_busy;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign div0      = div0_q;
  assign op_err    = op_err_q;

  // The divider takes its operands straight from the port on the accept edge.
  arith_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (accept && is_div_op(op)),
    .dividend_i  (a),
    .divisor_i   (b),
    .busy_o      (dv_busy),
    .done_o      (dv_done),
    .quotient_o  (dv_quot),
    .remainder_o (dv_rem),
    .div0_o      (dv_div0)
  );

  // Single-cycle datapath on the latched, zero-extended operands; wraps modulo 2^RES_W.
  always_comb begin
    a_x     = {{PAD{1'b0}}, a_q};
    b_x     = {{PAD{1'b0}}, b_q};
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_x + b_x;
      OP_SUB:  alu_res = a_x - b_x;
      OP_MUL:  alu_res = a_x * b_x;
      default: alu_res = '0;
    endcase
  end

  // Control FSM next-state, operand latch and result/flag capture.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    div0_d   = div0_q;
    op_err_d = op_err_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d   = 1'b0;
          result_d = alu_res;
          op_err_d = !is_legal_op(op_q);
          div0_d   = 1'b0;
          state_d  = DONE;
        end else if (accept) begin
          op_d     = op;
          a_d      = a;
          b_d      = b;
          result_d = '0;
          div0_d   = 1'b0;
          op_err_d = 1'b0;
          if (is_div_op(op)) state_d = DIV;
          else               pend_d  = 1'b1;
        end
      end
      DIV: begin
        if (dv_done) begin
          result_d = (op_q == OP_DIV) ? {{PAD{1'b0}}, dv_quot} : {{PAD{1'b0}}, dv_rem};
          div0_d   = dv_div0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      div0_q   <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      div0_q   <= div0_d;
      op_err_q <= op_err_d;
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed plus random stimulus for seq_arith_unit against an arithmetic reference model.
// Latency: checks accept-to-out_valid cycle counts per op class.
// Backpressure: holds out_ready low and checks output stability and accept blocking.
module tb_seq_arith_unit;

  localparam int W  = 4;
  localparam int RW = 2 * W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          div0;
  logic          op_err;

  int tests = 0;
  int fails = 0;

  logic [2:0]   r_op;
  logic [W-1:0] r_a, r_b;
  int           seen;
  int           lat2;

  seq_arith_unit #(.WIDTH(W), .RES_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div0      (div0),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic, reduced modulo 2^RW.
  function automatic int model_res(input int o, input int x, input int y);
    int m;
    m = 1 << RW;
    case (o)
      0:       return (x + y) % m;
      1:       return (x - y + m) % m;
      2:       return (x * y) % m;
      3:       return (y == 0) ? (1 << W) - 1 : x / y;
      4:       return (y == 0) ? x : x % y;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation, check latency/result/flags, hold for `hold` stalled cycles, then drain.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold);
    int lat;
    int exp;
    int is_div;
    exp    = model_res(int'(o), int'(x), int'(y));
    is_div = (o == 3'd3 || o == 3'd4) ? 1 : 0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = 4'($urandom);
    b  = 4'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, is_div ? W + 1 : 1);
    chk("result", result, exp);
    chk("div0", div0, (is_div != 0) && (y == 0));
    chk("op_err", op_err, o > 3'd4);
    chk("in_ready_busy", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      op = 3'($urandom);
      a  = 4'($urandom);
      b  = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, exp);
      chk("hold_flags", {div0, op_err}, {(is_div != 0) && (y == 0), o > 3'd4});
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {div0, op_err}, 2'b00);
    rst = 1'b0;

    // Directed arithmetic cases.
    run_op(3'd0, 4'd14, 4'd12, 0);
    run_op(3'd1, 4'd12, 4'd14, 0);
    run_op(3'd1, 4'd4,  4'd2,  0);
    run_op(3'd2, 4'd15, 4'd15, 0);
    run_op(3'd2, 4'd0,  4'd9,  0);
    run_op(3'd3, 4'd15, 4'd4,  0);
    run_op(3'd4, 4'd15, 4'd4,  0);
    run_op(3'd3, 4'd0,  4'd0,  0);
    run_op(3'd4, 4'd0,  4'd0,  0);
    run_op(3'd3, 4'd9,  4'd0,  1);
    run_op(3'd4, 4'd11, 4'd0,  0);
    run_op(3'd7, 4'd5,  4'd3,  0);

    // Backpressure: five stalled cycles in DONE.
    run_op(3'd0, 4'd7, 4'd8, 5);

    // A request held through the handshake is taken the cycle after it.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; a = 4'd3; b = 4'd4;
    @(posedge clk);
    @(negedge clk);
    op = 3'd2; a = 4'd5; b = 4'd6;
    repeat (3) @(negedge clk);
    chk("bp_first_result", result, 7);
    chk("bp_blocked", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after_hs", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", in_ready, 0);
    lat2 = 0;
    while (out_valid !== 1'b1 && lat2 < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat2++;
    end
    chk("bp_second_latency", lat2, 1);
    chk("bp_second_result", result, 30);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the second divider cycle aborts without emitting a result.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd3; a = 4'd15; b = 4'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk("abort_no_partial", seen, 0);
    run_op(3'd4, 4'd13, 4'd5, 0);

    // Randomized operations, biased toward zero divisors.
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = 4'($urandom);
      r_b  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      run_op(r_op, r_a, r_b, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
